la_capture_sequencer: RTL and testbench

//  Sequences the logic-analyzer shift-capture datapath in the observer_clk domain: arm, trigger

---
 rtl/la_seq_pkg.sv | 23 ++
 rtl/la_trig_detect.sv | 41 ++++
 rtl/la_capture_sequencer.sv | 156 +++++++++++++++
 tb/tb_la_capture_sequencer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/la_seq_pkg.sv
// rtl/la_seq_pkg.sv - shared state encodings, trigger mode codes and default widths
package la_seq_pkg;

  localparam int LA_DEPTH     = 1024;
  localparam int LA_DELAY_W   = 16;
  localparam int LA_TIMEOUT_W = 24;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_DELAY   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } la_state_e;

  typedef enum logic [1:0] {
    TRIG_RISE   = 2'b00,
    TRIG_FALL   = 2'b01,
    TRIG_EITHER = 2'b10,
    TRIG_LEVEL  = 2'b11
  } la_trig_mode_e;

endpackage

// File: rtl/la_trig_detect.sv
// rtl/la_trig_detect.sv - trigger synchronizer, history flop and mode select producing trig_hit
module la_trig_detect
  import la_seq_pkg::*;
(
  input  logic       observer_clk,
  input  logic       reset,
  input  logic       trig_in_i,
  input  logic [1:0] trig_mode_i,
  output logic       trig_hit_o
);

  (* ASYNC_REG = "TRUE" *) logic sync_meta_q;
  (* ASYNC_REG = "TRUE" *) logic sync_q;
  logic hist_q;

  // History tracks the synchronized level every cycle, so on entry to ARMED it
  // already holds the level seen during the arm cycle: a held level is not an edge.
  always_ff @(posedge observer_clk) begin
    if (reset) begin
      sync_meta_q <= 1'b0;
      sync_q      <= 1'b0;
      hist_q      <= 1'b0;
    end else begin
      sync_meta_q <= trig_in_i;
      sync_q      <= sync_meta_q;
      hist_q      <= sync_q;
    end
  end

  always_comb begin
    trig_hit_o = 1'b0;
    case (trig_mode_i)
      TRIG_RISE:   trig_hit_o = sync_q & ~hist_q;
      TRIG_FALL:   trig_hit_o = ~sync_q & hist_q;
      TRIG_EITHER: trig_hit_o = sync_q ^ hist_q;
      TRIG_LEVEL:  trig_hit_o = sync_q;
      default:     trig_hit_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/la_capture_sequencer.sv
// rtl/la_capture_sequencer.sv - arm/trigger/delay/capture sequencer driving capture load/shift strobes
// Optional forced-trigger timeout is built when LA_TRIG_TIMEOUT_EN is defined.
module la_capture_sequencer
  import la_seq_pkg::*;
#(
  parameter int pDEPTH     = LA_DEPTH,
  parameter int pCOUNT_W   = $clog2(pDEPTH),
  parameter int pDELAY_W   = LA_DELAY_W,
  parameter int pTIMEOUT_W = LA_TIMEOUT_W
) (
  input  logic                  observer_clk,
  input  logic                  reset,
  input  logic                  arm_i,
  input  logic                  abort_i,
  input  logic                  trig_in_i,
  input  logic [1:0]            trig_mode_i,
  input  logic [pDELAY_W-1:0]   trig_delay_i,
  input  logic [pCOUNT_W-1:0]   capture_len_i,
  input  logic [pTIMEOUT_W-1:0] timeout_cycles_i,
  output logic                  cap_load_o,
  output logic                  cap_shift_o,
  output logic [pCOUNT_W-1:0]   capture_count_o,
  output logic [2:0]            state_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  timed_out_o
);

  la_state_e             state_q;
  logic [1:0]            mode_q;
  logic [pDELAY_W-1:0]   delay_cfg_q;
  logic [pDELAY_W-1:0]   delay_cnt_q;
  logic [pCOUNT_W-1:0]   len_q;
  logic [pCOUNT_W-1:0]   count_q;
  logic                  cap_load_q;
  logic                  cap_shift_q;
  logic                  done_q;
  logic                  timed_out_q;
  logic                  trig_hit;
  logic                  forced_hit;
  logic                  fire;

  la_trig_detect u_trig_detect (
    .observer_clk (observer_clk),
    .reset        (reset),
    .trig_in_i    (trig_in_i),
    .trig_mode_i  (mode_q),
    .trig_hit_o   (trig_hit)
  );

`ifdef LA_TRIG_TIMEOUT_EN
  logic [pTIMEOUT_W-1:0] tmo_cfg_q;
  logic [pTIMEOUT_W-1:0] tmo_cnt_q;

  assign forced_hit = (tmo_cfg_q != '0) && (tmo_cnt_q == tmo_cfg_q);
`else
  logic unused_timeout;

  assign unused_timeout = ^timeout_cycles_i;
  assign forced_hit     = 1'b0;
`endif

  assign fire = trig_hit | forced_hit;

  always_ff @(posedge observer_clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mode_q      <= '0;
      delay_cfg_q <= '0;
      delay_cnt_q <= '0;
      len_q       <= '0;
      count_q     <= '0;
      cap_load_q  <= 1'b0;
      cap_shift_q <= 1'b0;
      done_q      <= 1'b0;
      timed_out_q <= 1'b0;
`ifdef LA_TRIG_TIMEOUT_EN
      tmo_cfg_q   <= '0;
      tmo_cnt_q   <= '0;
`endif
    end else if (abort_i) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      cap_load_q  <= 1'b0;
      cap_shift_q <= 1'b0;
      done_q      <= 1'b0;
      timed_out_q <= 1'b0;
    end else begin
      cap_load_q  <= 1'b0;
      cap_shift_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (arm_i) begin
            mode_q      <= trig_mode_i;
            delay_cfg_q <= trig_delay_i;
            len_q       <= capture_len_i;
            count_q     <= '0;
            done_q      <= 1'b0;
            timed_out_q <= 1'b0;
`ifdef LA_TRIG_TIMEOUT_EN
            tmo_cfg_q   <= timeout_cycles_i;
            tmo_cnt_q   <= '0;
`endif
            state_q     <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (fire) begin
            // A genuine trigger arriving with the timeout still counts as genuine.
            timed_out_q <= forced_hit & ~trig_hit;
            if (delay_cfg_q != '0) begin
              delay_cnt_q <= delay_cfg_q - pDELAY_W'(1);
              state_q     <= ST_DELAY;
            end else begin
              cap_load_q  <= 1'b1;
              state_q     <= ST_CAPTURE;
            end
          end
`ifdef LA_TRIG_TIMEOUT_EN
          else if ((tmo_cfg_q != '0) && (tmo_cnt_q != tmo_cfg_q)) begin
            tmo_cnt_q <= tmo_cnt_q + pTIMEOUT_W'(1);
          end
`endif
        end
        ST_DELAY: begin
          if (delay_cnt_q == '0) begin
            cap_load_q <= 1'b1;
            state_q    <= ST_CAPTURE;
          end else begin
            delay_cnt_q <= delay_cnt_q - pDELAY_W'(1);
          end
        end
        ST_CAPTURE: begin
          // count_q holds at len_q once the window closes, for readback in DONE.
          if (count_q == len_q) begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            count_q     <= count_q + pCOUNT_W'(1);
            cap_shift_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cap_load_o      = cap_load_q;
  assign cap_shift_o     = cap_shift_q;
  assign capture_count_o = count_q;
  assign state_o         = state_q;
  assign busy_o          = (state_q == ST_ARMED) || (state_q == ST_DELAY) || (state_q == ST_CAPTURE);
  assign done_o          = done_q;
  assign timed_out_o     = timed_out_q;

endmodule

// File: tb/tb_la_capture_sequencer.sv
// tb/tb_la_capture_sequencer.sv - randomized self-checking bench for la_capture_sequencer
module tb_la_capture_sequencer;

  logic        observer_clk = 1'b0;
  logic        reset = 1'b1;
  logic        arm_i = 1'b0;
  logic        abort_i = 1'b0;
  logic        trig_in_i = 1'b0;
  logic [1:0]  trig_mode_i = 2'b00;
  logic [15:0] trig_delay_i = 16'd0;
  logic [9:0]  capture_len_i = 10'd0;
  logic [23:0] timeout_cycles_i = 24'd0;
  logic        cap_load_o;
  logic        cap_shift_o;
  logic [9:0]  capture_count_o;
  logic [2:0]  state_o;
  logic        busy_o;
  logic        done_o;
  logic        timed_out_o;

  int checks = 0;
  int errors = 0;

  always #5 observer_clk = ~observer_clk;

  la_capture_sequencer dut (
    .observer_clk     (observer_clk),
    .reset            (reset),
    .arm_i            (arm_i),
    .abort_i          (abort_i),
    .trig_in_i        (trig_in_i),
    .trig_mode_i      (trig_mode_i),
    .trig_delay_i     (trig_delay_i),
    .capture_len_i    (capture_len_i),
    .timeout_cycles_i (timeout_cycles_i),
    .cap_load_o       (cap_load_o),
    .cap_shift_o      (cap_shift_o),
    .capture_count_o  (capture_count_o),
    .state_o          (state_o),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .timed_out_o      (timed_out_o)
  );

  function automatic logic [17:0] observed();
    return {state_o, cap_load_o, cap_shift_o, busy_o, done_o, timed_out_o, capture_count_o};
  endfunction

  // Expected outputs at sample t, given arm sample a, first-sample cycle l0, delay d and length len.
  function automatic logic [17:0] expect_at(int t, int l0, int d, int len, bit tmo);
    logic [2:0] st;
    int cnt;
    if (t >= l0 + len + 1) st = 3'd4;
    else if (t >= l0)      st = 3'd3;
    else if (t >= l0 - d)  st = 3'd2;
    else                   st = 3'd1;
    if (t < l0) cnt = 0;
    else cnt = (t - l0 > len) ? len : t - l0;
    return {st, 1'(t == l0), 1'(t > l0 && t <= l0 + len), 1'(st >= 3'd1 && st <= 3'd3),
            1'(st == 3'd4), 1'(tmo && t >= l0 - d), 10'(cnt)};
  endfunction

  // rmode: 0 = abort first, no stray arm; 1 = stray arm anywhere while busy; 2 = stray arm mid-capture
  task automatic run_trial(input logic [1:0] mode, input int d, input int len, input logic pre,
                           input int w, input int rmode, input int tmo);
    int a, tt, l0, r, last;
    logic [17:0] exp_w, got;
    a  = 6;
    tt = a + 1 + w;
    if (tmo > 0)                    l0 = a + 2 + tmo + d;
    else if (mode == 2'b11 && pre)  l0 = a + 2 + d;
    else                            l0 = tt + 3 + d;
    if (rmode == 2) r = l0 + len / 2;
    else            r = a + 1 + $urandom_range(0, l0 + len - a - 1);
    last = l0 + len + 3;
    for (int t = 0; t <= last; t++) begin
      @(negedge observer_clk);
      if (t > a) begin
        exp_w = expect_at(t, l0, d, len, tmo > 0);
        got   = observed();
        checks++;
        if (got !== exp_w) begin
          errors++;
          $display("FAIL trace mode=%0d d=%0d len=%0d t=%0d got=%h expected=%h", mode, d, len, t, got, exp_w);
        end
      end
      abort_i = (t == 0) && (rmode == 0);
      arm_i   = (t == a) || (rmode != 0 && t == r);
      if (t == 0) trig_in_i = pre;
      if (t == tt && tmo == 0 && !(mode == 2'b11 && pre)) trig_in_i = ~pre;
      if (t == a) begin
        trig_mode_i      = mode;
        trig_delay_i     = 16'(d);
        capture_len_i    = 10'(len);
        timeout_cycles_i = 24'(tmo);
      end else if (t > a) begin
        trig_mode_i      = 2'($urandom);
        trig_delay_i     = 16'($urandom);
        capture_len_i    = 10'($urandom);
        timeout_cycles_i = 24'($urandom_range(1, 5));
      end
    end
    arm_i   = 1'b0;
    abort_i = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge observer_clk);
    checks++;
    if (observed() !== 18'd0) begin
      errors++;
      $display("FAIL reset_held got=%h expected=%h", observed(), 18'd0);
    end
    reset = 1'b0;
    @(negedge observer_clk);
    checks++;
    if (observed() !== 18'd0) begin
      errors++;
      $display("FAIL reset_released got=%h expected=%h", observed(), 18'd0);
    end
  endtask

  task automatic test_basic();
    run_trial(2'b00, 0, 7, 1'b0, 3, 0, 0);
  endtask

  task automatic test_delay_len0();
    run_trial(2'b00, 5, 0, 1'b0, 2, 0, 0);
  endtask

  task automatic test_preset_level();
    run_trial(2'b01, 0, 3, 1'b1, 10, 0, 0);
    run_trial(2'b10, 2, 2, 1'b1, 8, 0, 0);
    run_trial(2'b11, 0, 4, 1'b1, 5, 0, 0);
    run_trial(2'b11, 3, 1, 1'b0, 4, 0, 0);
  endtask

  task automatic test_abort();
    int a, l0;
    logic [17:0] got;
    a  = 6;
    l0 = a + 1 + 3;
    for (int t = 0; t <= l0 + 5; t++) begin
      @(negedge observer_clk);
      got = observed();
      if (t > a && t <= l0 + 3) begin
        checks++;
        if (got !== expect_at(t, l0, 0, 1023, 1'b0)) begin
          errors++;
          $display("FAIL abort_pre t=%0d got=%h expected=%h", t, got, expect_at(t, l0, 0, 1023, 1'b0));
        end
      end
      if (t == l0 + 4 || t == l0 + 5) begin
        checks++;
        if (got[17:10] !== 8'd0) begin
          errors++;
          $display("FAIL abort_idle t=%0d got=%h expected=%h", t, got[17:10], 8'd0);
        end
      end
      abort_i   = (t == 0) || (t == l0 + 3) || (t == l0 + 4);
      arm_i     = (t == a) || (t == l0 + 4);
      trig_in_i = (t > a);
      if (t == a) begin
        trig_mode_i      = 2'b00;
        trig_delay_i     = 16'd0;
        capture_len_i    = 10'd1023;
        timeout_cycles_i = 24'd0;
      end
    end
    abort_i = 1'b0;
    arm_i   = 1'b0;
    run_trial(2'b00, 1, 5, 1'b0, 1, 0, 0);
  endtask

  task automatic test_arm_while_busy();
    run_trial(2'b00, 0, 12, 1'b0, 2, 2, 0);
    run_trial(2'b10, 4, 9, 1'b0, 3, 2, 0);
  endtask

  task automatic test_reset_mid_delay();
    int a, l0;
    logic [17:0] got;
    a  = 6;
    l0 = a + 1 + 3 + 30;
    for (int t = 0; t <= 31; t++) begin
      @(negedge observer_clk);
      got = observed();
      if (t > a && t <= 30) begin
        checks++;
        if (got !== expect_at(t, l0, 30, 4, 1'b0)) begin
          errors++;
          $display("FAIL delay_pre t=%0d got=%h expected=%h", t, got, expect_at(t, l0, 30, 4, 1'b0));
        end
      end
      if (t == 31) begin
        checks++;
        if (got !== 18'd0) begin
          errors++;
          $display("FAIL reset_mid_delay got=%h expected=%h", got, 18'd0);
        end
      end
      abort_i   = (t == 0);
      arm_i     = (t == a);
      trig_in_i = (t > a);
      reset     = (t == 30);
      if (t == a) begin
        trig_mode_i      = 2'b00;
        trig_delay_i     = 16'd30;
        capture_len_i    = 10'd4;
        timeout_cycles_i = 24'd0;
      end
    end
    reset   = 1'b0;
    abort_i = 1'b0;
    arm_i   = 1'b0;
  endtask

  task automatic test_full_depth();
    run_trial(2'b00, 0, 1023, 1'b0, 0, 0, 0);
  endtask

  task automatic test_random();
    logic [1:0] m;
    logic p;
    for (int i = 0; i < 24; i++) begin
      m = 2'($urandom_range(0, 3));
      case (m)
        2'b00:   p = 1'b0;
        2'b01:   p = 1'b1;
        default: p = 1'($urandom);
      endcase
      run_trial(m, $urandom_range(0, 12), $urandom_range(0, 40), p, $urandom_range(0, 8), 1, 0);
    end
  endtask

`ifdef LA_TRIG_TIMEOUT_EN
  task automatic test_timeout();
    run_trial(2'b00, 0, 3, 1'b0, 0, 0, 100);
    run_trial(2'b01, 4, 2, 1'b1, 0, 0, 37);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_delay_len0();
    test_preset_level();
    test_abort();
    test_arm_while_busy();
    test_reset_mid_delay();
    test_full_depth();
    test_random();
`ifdef LA_TRIG_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
